// File: rtl/mac_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mac_layer_sequencer
//
// Sequences a 4x4 systolic MAC array through one or more back-to-back layers.
// A feature block captured on start is presented to the array one row per
// cycle. The sequencer then waits for the array's result strobe. On
// intermediate layers the result is fed back as the next layer's rows. On the
// final layer the result is published on result_out.
//
// Optional feature: define ACTIVATION_RELU_EN to clamp negative signed
// ROW_W-bit lanes of mac_result to zero before capture. The default build
// captures mac_result unmodified. Control timing is the same in both builds.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous, active-low reset
//   start         in   single-cycle run request, accepted only in IDLE
//   num_layers    in   layers to run (0 is treated as 1), sampled on start
//   feature_in    in   layer-0 feature block, sampled on start
//   mac_load      out  pulse on the first row of each layer
//   row_valid     out  row_data carries a valid row
//   row_data      out  current row to the array
//   mac_valid_out in   array result-valid strobe
//   mac_result    in   array result block
//   result_out    out  final-layer result, held until overwritten
//   result_valid  out  one-cycle pulse when result_out updates
//   busy          out  high in any state except IDLE
//   layer_idx     out  0-based index of the layer in progress
//   timeout_err   out  sticky wait timeout, cleared on the next accepted start
// -----------------------------------------------------------------------------
module mac_layer_sequencer #(
  parameter int ROW_W       = 32,
  parameter int N_ROWS      = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int LAYER_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LAYER_W-1:0]        num_layers,
  input  logic [ROW_W*N_ROWS-1:0]   feature_in,
  output logic                      mac_load,
  output logic                      row_valid,
  output logic [ROW_W-1:0]          row_data,
  input  logic                      mac_valid_out,
  input  logic [ROW_W*N_ROWS-1:0]   mac_result,
  output logic [ROW_W*N_ROWS-1:0]   result_out,
  output logic                      result_valid,
  output logic                      busy,
  output logic [LAYER_W-1:0]        layer_idx,
  output logic                      timeout_err
);

  localparam int BLK_W     = ROW_W * N_ROWS;
  localparam int ROW_CNT_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int TMO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q,       state_d;
  logic [BLK_W-1:0]       buf_q,         buf_d;
  logic [BLK_W-1:0]       result_q,      result_d;
  logic [ROW_CNT_W-1:0]   row_cnt_q,     row_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q,     tmo_cnt_d;
  logic [LAYER_W-1:0]     layers_q,      layers_d;
  logic [LAYER_W-1:0]     layer_idx_q,   layer_idx_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [ROW_W-1:0]       rows [N_ROWS];
  logic [BLK_W-1:0]       mac_result_act;

  // Result post-processing applied before capture into the buffer or result_out.
  function automatic logic [BLK_W-1:0] activate(input logic [BLK_W-1:0] blk);
    logic [BLK_W-1:0] res;
    res = blk;
`ifdef ACTIVATION_RELU_EN
    for (int i = 0; i < N_ROWS; i++) begin
      if (blk[i*ROW_W + ROW_W - 1]) res[i*ROW_W +: ROW_W] = '0;
    end
`endif
    return res;
  endfunction

  assign mac_result_act = activate(mac_result);

  // Row 0 is the most significant slice of the block.
  always_comb begin
    for (int i = 0; i < N_ROWS; i++) begin
      rows[i] = buf_q[(N_ROWS-1-i)*ROW_W +: ROW_W];
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every _d signal is defaulted to its _q value first, so no path
    // can leave one unassigned and infer a latch.
    state_d       = state_q;
    buf_d         = buf_q;
    result_d      = result_q;
    row_cnt_d     = row_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    layers_d      = layers_q;
    layer_idx_d   = layer_idx_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d         = feature_in;
          layers_d      = (num_layers == '0) ? LAYER_W'(1) : num_layers;
          layer_idx_d   = '0;
          timeout_err_d = 1'b0;
          row_cnt_d     = '0;
          state_d       = S_FEED;
        end
      end

      S_FEED: begin
        // The row counter parks on the last row so row_data holds it in WAIT.
        if (row_cnt_q == ROW_CNT_W'(N_ROWS - 1)) begin
          tmo_cnt_d = '0;
          state_d   = S_WAIT;
        end else begin
          row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
        end
      end

      S_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A strobe wins over a timeout on the same cycle.
        if (mac_valid_out) begin
          if (layer_idx_q == layers_q - LAYER_W'(1)) begin
            result_d = mac_result_act;
            state_d  = S_DONE;
          end else begin
            buf_d       = mac_result_act;
            layer_idx_d = layer_idx_q + LAYER_W'(1);
            row_cnt_d   = '0;
            state_d     = S_FEED;
          end
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      // NOTE: the feature buffer is ordinary flops rather than a RAM, so it is
      // reset too; row_data reads straight from it and must be 0 out of reset.
      buf_q         <= '0;
      result_q      <= '0;
      row_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      layers_q      <= '0;
      layer_idx_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values regardless of statement order.
      state_q       <= state_d;
      buf_q         <= buf_d;
      result_q      <= result_d;
      row_cnt_q     <= row_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      layers_q      <= layers_d;
      layer_idx_q   <= layer_idx_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign row_valid    = (state_q == S_FEED);
  assign mac_load     = (state_q == S_FEED) && (row_cnt_q == '0);
  assign row_data     = rows[row_cnt_q];
  assign result_out   = result_q;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign layer_idx    = layer_idx_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_layer_sequencer
//
// Directed bench for mac_layer_sequencer. Inputs are driven and outputs are
// sampled 1 ns after each rising clock edge. Expected values are hand-written
// constants, plus the row ordering of the block presented to the array.
// -----------------------------------------------------------------------------
module tb_mac_layer_sequencer;

  localparam int TIMEOUT_CYC = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   num_layers;
  logic [127:0] feature_in;
  logic         mac_load;
  logic         row_valid;
  logic [31:0]  row_data;
  logic         mac_valid_out;
  logic [127:0] mac_result;
  logic [127:0] result_out;
  logic         result_valid;
  logic         busy;
  logic [3:0]   layer_idx;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  mac_layer_sequencer #(
    .ROW_W      (32),
    .N_ROWS     (4),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .LAYER_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_layers   (num_layers),
    .feature_in   (feature_in),
    .mac_load     (mac_load),
    .row_valid    (row_valid),
    .row_data     (row_data),
    .mac_valid_out(mac_valid_out),
    .mac_result   (mac_result),
    .result_out   (result_out),
    .result_valid (result_valid),
    .busy         (busy),
    .layer_idx    (layer_idx),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts a run; returns in the first FEED cycle.
  task automatic do_start(input logic [3:0] nl, input logic [127:0] feat);
    start      = 1'b1;
    num_layers = nl;
    feature_in = feat;
    tick();
    start      = 1'b0;
  endtask

  // Called in the first FEED cycle; checks all four rows and returns in the
  // first WAIT cycle. With disturb set, a start with different inputs and a
  // spurious result strobe are injected mid-feed.
  task automatic check_feed(input string tag, input logic [127:0] blk,
                            input logic [3:0] exp_layer, input bit disturb);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s_rv%0d", tag, r), 128'(row_valid), 128'(1));
      check($sformatf("%s_load%0d", tag, r), 128'(mac_load), 128'(r == 0));
      check($sformatf("%s_row%0d", tag, r), 128'(row_data), 128'(blk[(3-r)*32 +: 32]));
      check($sformatf("%s_layer%0d", tag, r), 128'(layer_idx), 128'(exp_layer));
      if (disturb) begin
        if (r == 1) begin
          start      = 1'b1;
          num_layers = 4'd5;
          feature_in = ~blk;
        end else if (r == 2) begin
          start         = 1'b0;
          mac_valid_out = 1'b1;
          mac_result    = 128'h12345678_12345678_12345678_12345678;
        end else if (r == 3) begin
          mac_valid_out = 1'b0;
        end
      end
      tick();
    end
    check({tag, "_wait_rv"}, 128'(row_valid), 128'(0));
    check({tag, "_wait_load"}, 128'(mac_load), 128'(0));
    check({tag, "_wait_hold"}, 128'(row_data), 128'(blk[31:0]));
    check({tag, "_wait_busy"}, 128'(busy), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] feat1, feat2, feat3;
    logic [127:0] res_a, res_b, res_c, relu_in, relu_exp;
    int pulses;

    feat1   = {4{8'd1, 8'd2, 8'd3, 8'd4}};
    feat2   = 128'h11111111_22222222_33333333_44444444;
    feat3   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    res_a   = 128'h00000001_00000002_00000003_00000004;
    res_b   = 128'h000000AB_000000CD_000000EF_00000012;
    res_c   = 128'h00000001_00000002_00000003_00000005;
    relu_in = 128'hFFFFFFF0_00000010_80000000_7FFFFFFF;
`ifdef ACTIVATION_RELU_EN
    relu_exp = 128'h00000000_00000010_00000000_7FFFFFFF;
`else
    relu_exp = relu_in;
`endif

    reset         = 1'b0;
    start         = 1'b0;
    num_layers    = '0;
    feature_in    = '0;
    mac_valid_out = 1'b0;
    mac_result    = '0;

    // Reset state.
    tick();
    tick();
    check("rst_busy",   128'(busy),         128'(0));
    check("rst_rv",     128'(row_valid),    128'(0));
    check("rst_load",   128'(mac_load),     128'(0));
    check("rst_row",    128'(row_data),     128'(0));
    check("rst_res",    result_out,         128'(0));
    check("rst_resv",   128'(result_valid), 128'(0));
    check("rst_layer",  128'(layer_idx),    128'(0));
    check("rst_tmo",    128'(timeout_err),  128'(0));
    reset = 1'b1;
    tick();

    // Single layer.
    do_start(4'd1, feat1);
    check_feed("l1", feat1, 4'd0, 1'b0);
    tick();
    mac_valid_out = 1'b1;
    mac_result    = 128'hAA;
    tick();
    mac_valid_out = 1'b0;
    check("l1_resv",     128'(result_valid), 128'(1));
    check("l1_res",      result_out,         128'hAA);
    check("l1_done_bsy", 128'(busy),         128'(1));
    tick();
    check("l1_idle_bsy", 128'(busy),         128'(0));
    check("l1_idle_rv",  128'(result_valid), 128'(0));
    check("l1_idle_res", result_out,         128'hAA);

    // Two layers with feedback; start during DONE is ignored.
    do_start(4'd2, feat2);
    check_feed("l2a", feat2, 4'd0, 1'b0);
    mac_valid_out = 1'b1;
    mac_result    = res_a;
    tick();
    mac_valid_out = 1'b0;
    check_feed("l2b", res_a, 4'd1, 1'b0);
    check("l2b_noresv", 128'(result_valid), 128'(0));
    mac_valid_out = 1'b1;
    mac_result    = res_b;
    tick();
    mac_valid_out = 1'b0;
    check("l2_resv",  128'(result_valid), 128'(1));
    check("l2_res",   result_out,         res_b);
    check("l2_layer", 128'(layer_idx),    128'(1));
    start      = 1'b1;
    num_layers = 4'd1;
    feature_in = ~feat2;
    tick();
    start = 1'b0;
    check("done_start_bsy0", 128'(busy), 128'(0));
    tick();
    check("done_start_bsy1", 128'(busy), 128'(0));

    // Timeout: no strobe in WAIT.
    do_start(4'd1, feat1);
    check_feed("to", feat1, 4'd0, 1'b0);
    pulses = 0;
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      check($sformatf("to_busy%0d", k), 128'(busy), 128'(1));
      if (result_valid) pulses++;
      tick();
    end
    check("to_err",    128'(timeout_err),  128'(1));
    check("to_busy",   128'(busy),         128'(0));
    check("to_resv",   128'(result_valid), 128'(0));
    check("to_pulses", 128'(pulses),       128'(0));
    check("to_res",    result_out,         res_b);
    tick();
    check("to_sticky", 128'(timeout_err),  128'(1));

    // num_layers=0 runs one layer; start and strobe during FEED are ignored.
    do_start(4'd0, feat3);
    check("to_clear", 128'(timeout_err), 128'(0));
    check_feed("edge", feat3, 4'd0, 1'b1);
    mac_valid_out = 1'b1;
    mac_result    = res_c;
    tick();
    mac_valid_out = 1'b0;
    check("edge_resv",  128'(result_valid), 128'(1));
    check("edge_res",   result_out,         res_c);
    check("edge_layer", 128'(layer_idx),    128'(0));
    tick();
    check("edge_idle",  128'(busy),         128'(0));

    // Reset mid-WAIT, then a clean run carrying the activation vector.
    do_start(4'd2, feat2);
    check_feed("rw", feat2, 4'd0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("rw_busy",  128'(busy),         128'(0));
    check("rw_rv",    128'(row_valid),    128'(0));
    check("rw_row",   128'(row_data),     128'(0));
    check("rw_res",   result_out,         128'(0));
    check("rw_resv",  128'(result_valid), 128'(0));
    check("rw_layer", 128'(layer_idx),    128'(0));
    check("rw_tmo",   128'(timeout_err),  128'(0));
    tick();
    reset = 1'b1;
    tick();
    check("rw_idle",  128'(busy), 128'(0));
    do_start(4'd1, feat1);
    check_feed("post", feat1, 4'd0, 1'b0);
    mac_valid_out = 1'b1;
    mac_result    = relu_in;
    tick();
    mac_valid_out = 1'b0;
    check("act_resv", 128'(result_valid), 128'(1));
    check("act_res",  result_out,         relu_exp);
    tick();
    check("act_idle", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
